// File: rtl/count_sum_pkg.sv
// Shared types and default sizes for the counter-summation controller and datapath.
package count_sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_SUM_W = 8;

endpackage

// File: rtl/count_sum_datapath.sv
// Counter, running-sum register with carry-out, and sticky overflow flop.
// Every register is written only when the controller raises the matching enable.
module count_sum_datapath import count_sum_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             cnt_en,
  input  logic             sum_en,
  input  logic             last,
  output logic [WIDTH-1:0] count,
  output logic [SUM_W-1:0] sum,
  output logic             ovf
);

  // One extra bit catches the carry-out of the wrapping add.
  logic [SUM_W:0] add;

  assign add = {1'b0, sum} + (SUM_W+1)'(count);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      sum   <= '0;
      ovf   <= 1'b0;
    end else begin
      // Termination precedes the increment, so the counter never wraps.
      if (cnt_en && !last) begin
        count <= count + 1'b1;
      end
      if (sum_en) begin
        sum <= add[SUM_W-1:0];
        ovf <= ovf | add[SUM_W];
      end
    end
  end

endmodule

// File: rtl/count_sum_ctrl.sv
// Sequencing FSM for the counter-summation datapath: accepts a run request,
// steps the counter up to the latched limit, and pulses done for one cycle.
module count_sum_ctrl import count_sum_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             cnt_en,
  output logic             sum_en,
  output logic [1:0]       state
);

  // Handshake: start is a level request sampled only in IDLE; it is neither
  // queued nor acknowledged in RUN/DONE. done is a single-cycle pulse.
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] lim_q;
  logic             clear;
  logic             last;

  assign last  = (count == lim_q);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        lim_q <= limit;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          cnt_en = 1'b1;
          if (last) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sum_en = cnt_en;

  count_sum_datapath #(
    .WIDTH(WIDTH),
    .SUM_W(SUM_W)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .cnt_en (cnt_en),
    .sum_en (sum_en),
    .last   (last),
    .count  (count),
    .sum    (sum),
    .ovf    (ovf)
  );

endmodule

// File: tb/tb_count_sum_ctrl.sv
// Directed bench for count_sum_ctrl: an 8-bit-sum instance for most scenarios
// and a 6-bit-sum instance for the wrap/overflow scenario.
module tb_count_sum_ctrl;
  import count_sum_pkg::*;

  int checks = 0;
  int errors = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] limit = 4'd0;
  logic       hold = 1'b0;
  logic [3:0] count;
  logic [7:0] sum;
  logic       busy, done, ovf, cnt_en, sum_en;
  logic [1:0] state;

  logic       start_b = 1'b0;
  logic [3:0] limit_b = 4'd0;
  logic [3:0] count_b;
  logic [5:0] sum_b;
  logic       busy_b, done_b, ovf_b, cnt_en_b, sum_en_b;
  logic [1:0] state_b;

  always #5 clk = ~clk;

  count_sum_ctrl #(.WIDTH(4), .SUM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .limit(limit), .hold(hold),
    .count(count), .sum(sum), .busy(busy), .done(done), .ovf(ovf),
    .cnt_en(cnt_en), .sum_en(sum_en), .state(state)
  );

  count_sum_ctrl #(.WIDTH(4), .SUM_W(6)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .limit(limit_b), .hold(1'b0),
    .count(count_b), .sum(sum_b), .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .cnt_en(cnt_en_b), .sum_en(sum_en_b), .state(state_b)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] lim);
    limit = lim;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    while (!done_b && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || sum !== 8'd0 || busy !== 1'b0 || done !== 1'b0 ||
        ovf !== 1'b0 || cnt_en !== 1'b0 || state !== IDLE) begin
      errors++;
      $display("FAIL reset: count=%0d sum=%0d busy=%b done=%b ovf=%b cnt_en=%b state=%0d expected 0/0/0/0/0/0/0",
               count, sum, busy, done, ovf, cnt_en, state);
    end
  endtask

  task automatic test_basic();
    int busy_cycles;
    int exp_sum;
    busy_cycles = 0;
    exp_sum = 0;
    do_start(4'd5);
    limit = 4'd2;  // must be ignored while running
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (busy !== 1'b1 || count !== 4'(i) || sum !== 8'(exp_sum) || cnt_en !== 1'b1 || sum_en !== 1'b1) begin
        errors++;
        $display("FAIL basic_step%0d: busy=%b count=%0d sum=%0d en=%b%b expected 1/%0d/%0d/11",
                 i, busy, count, sum, cnt_en, sum_en, i, exp_sum);
      end
      exp_sum += i;
      busy_cycles++;
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'd15 || count !== 4'd5 || ovf !== 1'b0 || busy_cycles != 6) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b sum=%0d count=%0d ovf=%b expected 1/0/15/5/0",
               done, busy, sum, count, ovf);
    end
    step();
    checks++;
    if (done !== 1'b0 || state !== IDLE || sum !== 8'd15 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b state=%0d sum=%0d cnt_en=%b expected 0/0/15/0",
               done, state, sum, cnt_en);
    end
  endtask

  task automatic test_limit_max();
    int n;
    do_start(4'd15);
    wait_done(n);
    checks++;
    if (n != 16 || sum !== 8'd120 || count !== 4'd15 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL limit_max: cycles=%0d sum=%0d count=%0d ovf=%b expected 16/120/15/0",
               n, sum, count, ovf);
    end
    step();
    checks++;
    if (count !== 4'd15 || state !== IDLE) begin
      errors++;
      $display("FAIL limit_max_nowrap: count=%0d state=%0d expected 15/0", count, state);
    end
  endtask

  task automatic test_hold();
    int n;
    do_start(4'd6);
    step();
    step();
    hold = 1'b1;
    #1;
    checks++;
    if (cnt_en !== 1'b0 || sum_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_en: cnt_en=%b sum_en=%b busy=%b expected 0/0/1", cnt_en, sum_en, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 4'd2 || sum !== 8'd1 || state !== RUN) begin
        errors++;
        $display("FAIL hold_frozen%0d: count=%0d sum=%0d state=%0d expected 2/1/1", i, count, sum, state);
      end
    end
    hold = 1'b0;
    wait_done(n);
    checks++;
    if (n != 5 || sum !== 8'd21 || count !== 4'd6) begin
      errors++;
      $display("FAIL hold_done: remaining_cycles=%0d sum=%0d count=%0d expected 5/21/6", n, sum, count);
    end
    step();
  endtask

  task automatic test_ovf();
    int n;
    limit_b = 4'd15;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    wait_done_b(n);
    checks++;
    if (n != 16 || sum_b !== 6'd56 || ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_wrap: cycles=%0d sum=%0d ovf=%b expected 16/56/1", n, sum_b, ovf_b);
    end
    step();
    step();
    step();
    checks++;
    if (ovf_b !== 1'b1 || sum_b !== 6'd56 || state_b !== IDLE) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b sum=%0d state=%0d expected 1/56/0", ovf_b, sum_b, state_b);
    end
    limit_b = 4'd1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    checks++;
    if (ovf_b !== 1'b0 || sum_b !== 6'd0 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b sum=%0d busy=%b expected 0/0/1", ovf_b, sum_b, busy_b);
    end
    wait_done_b(n);
    checks++;
    if (n != 2 || sum_b !== 6'd1 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL ovf_rerun: cycles=%0d sum=%0d ovf=%b expected 2/1/0", n, sum_b, ovf_b);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_start(4'd9);
    start = 1'b1;
    limit = 4'd3;
    step();
    step();
    start = 1'b0;
    checks++;
    if (state !== RUN || count !== 4'd2 || sum !== 8'd1) begin
      errors++;
      $display("FAIL start_in_run: state=%0d count=%0d sum=%0d expected 1/2/1", state, count, sum);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (state !== IDLE || count !== 4'd0 || sum !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: state=%0d count=%0d sum=%0d busy=%b done=%b expected 0/0/0/0/0",
               state, count, sum, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || state !== IDLE) begin
        errors++;
        $display("FAIL mid_reset_idle%0d: done=%b state=%0d expected 0/0", i, done, state);
      end
    end
    do_start(4'd2);
    wait_done(n);
    limit = 4'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (n != 3 || state !== IDLE || busy !== 1'b0 || sum !== 8'd3) begin
      errors++;
      $display("FAIL start_in_done: cycles=%0d state=%0d busy=%b sum=%0d expected 3/0/0/3", n, state, busy, sum);
    end
    step();
    checks++;
    if (state !== IDLE || sum !== 8'd3) begin
      errors++;
      $display("FAIL start_not_queued: state=%0d sum=%0d expected 0/3", state, sum);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(4'd0);
    checks++;
    if (busy !== 1'b1 || cnt_en !== 1'b1) begin
      errors++;
      $display("FAIL lim0_run: busy=%b cnt_en=%b expected 1/1", busy, cnt_en);
    end
    wait_done(n);
    checks++;
    if (n != 1 || sum !== 8'd0 || count !== 4'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL lim0_done: cycles=%0d sum=%0d count=%0d done=%b expected 1/0/0/1", n, sum, count, done);
    end
    limit = 4'd3;
    start = 1'b1;
    step();
    checks++;
    if (state !== IDLE || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: state=%0d done=%b expected 0/0", state, done);
    end
    step();
    start = 1'b0;
    checks++;
    if (state !== RUN || count !== 4'd0 || sum !== 8'd0) begin
      errors++;
      $display("FAIL b2b_accept: state=%0d count=%0d sum=%0d expected 1/0/0", state, count, sum);
    end
    wait_done(n);
    checks++;
    if (n != 4 || sum !== 8'd6 || count !== 4'd3) begin
      errors++;
      $display("FAIL b2b_done: cycles=%0d sum=%0d count=%0d expected 4/6/3", n, sum, count);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit_max();
    test_hold();
    test_ovf();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
